// File: rtl/hci_ecc_err_monitor.sv
// ECC error monitor for the HCI streamer response path: accepted-beat error counting,
// first-uncorrectable-fault capture and an OK/DEGRADED/FAULT health FSM driving a level irq.
module hci_ecc_err_monitor #(
    parameter  int N_CHUNK   = 4,
    parameter  int CNT_W     = 16,
    parameter  int THRESHOLD = 8,
    localparam int CIDX_W    = $clog2(N_CHUNK + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               ack_i,
    input  logic               valid_i,
    input  logic [N_CHUNK-1:0] r_data_single_err_i,
    input  logic [N_CHUNK-1:0] r_data_multi_err_i,
    input  logic               r_meta_single_err_i,
    input  logic               r_meta_multi_err_i,
    output logic [CNT_W-1:0]   single_cnt_o,
    output logic [CNT_W-1:0]   multi_cnt_o,
    output logic [CNT_W-1:0]   win_cnt_o,
    output logic [CNT_W-1:0]   beat_cnt_o,
    output logic               sat_o,
    output logic               fault_valid_o,
    output logic [CIDX_W-1:0]  fault_chunk_o,
    output logic [CNT_W-1:0]   fault_beat_o,
    output logic [1:0]         state_o,
    output logic               irq_o
);

    // Per-beat error counts span 0..N_CHUNK+1, one more than the chunk index range.
    localparam int                 S_W     = $clog2(N_CHUNK + 2);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   THRESH  = CNT_W'(THRESHOLD);
    localparam logic [CIDX_W-1:0]  META_IDX = CIDX_W'(N_CHUNK);

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    // Returns {clamped, value}: value saturates at CNT_MAX.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [S_W-1:0]   b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(b);
        if (sum[CNT_W]) begin
            return {1'b1, CNT_MAX};
        end
        return sum;
    endfunction

    logic [CNT_W-1:0]  single_q, single_d;
    logic [CNT_W-1:0]  multi_q, multi_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              sat_q, sat_d;
    logic              fault_valid_q, fault_valid_d;
    logic [CIDX_W-1:0] fault_chunk_q, fault_chunk_d;
    logic [CNT_W-1:0]  fault_beat_q, fault_beat_d;
    state_e            state_q, state_d;

    logic [N_CHUNK-1:0] data_single_eff;
    logic               meta_single_eff;
    logic [S_W-1:0]     s_cnt, m_cnt;
    logic [S_W-1:0]     s_beat, m_beat;
    logic               beat_has_multi;
    logic [CIDX_W-1:0]  first_idx;
    logic [CNT_W-1:0]   win_base;
    logic [CNT_W:0]     single_sum, multi_sum, win_sum;

    // A chunk flagging both corrected and uncorrectable counts as uncorrectable only.
    assign data_single_eff = r_data_single_err_i & ~r_data_multi_err_i;
    assign meta_single_eff = r_meta_single_err_i & ~r_meta_multi_err_i;

    // NOTE: every signal driven in always_comb gets a default before any branch, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        s_cnt     = S_W'(meta_single_eff);
        m_cnt     = S_W'(r_meta_multi_err_i);
        first_idx = META_IDX;
        for (int i = N_CHUNK - 1; i >= 0; i--) begin
            s_cnt = s_cnt + S_W'(data_single_eff[i]);
            m_cnt = m_cnt + S_W'(r_data_multi_err_i[i]);
            if (r_data_multi_err_i[i]) begin
                first_idx = CIDX_W'(i);
            end
        end
    end

    assign s_beat         = valid_i ? s_cnt : '0;
    assign m_beat         = valid_i ? m_cnt : '0;
    assign beat_has_multi = valid_i && (m_cnt != '0);

    // Ack restarts the window in OK and DEGRADED; a beat in the same cycle lands on the fresh window.
    assign win_base   = (ack_i && (state_q != ST_FAULT)) ? '0 : win_q;
    assign single_sum = sat_add(single_q, s_beat);
    assign multi_sum  = sat_add(multi_q, m_beat);
    assign win_sum    = sat_add(win_base, s_beat);

    always_comb begin
        single_d      = single_sum[CNT_W-1:0];
        multi_d       = multi_sum[CNT_W-1:0];
        win_d         = win_sum[CNT_W-1:0];
        beat_d        = valid_i ? beat_q + CNT_W'(1) : beat_q;
        sat_d         = sat_q | single_sum[CNT_W] | multi_sum[CNT_W] | win_sum[CNT_W];
        fault_valid_d = fault_valid_q;
        fault_chunk_d = fault_chunk_q;
        fault_beat_d  = fault_beat_q;
        if (!fault_valid_q && beat_has_multi) begin
            fault_valid_d = 1'b1;
            fault_chunk_d = first_idx;
            fault_beat_d  = beat_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OK: begin
                if (beat_has_multi) begin
                    state_d = ST_FAULT;
                end else if (win_d >= THRESH) begin
                    state_d = ST_DEGRADED;
                end
            end
            ST_DEGRADED: begin
                if (beat_has_multi) begin
                    state_d = ST_FAULT;
                end else if (ack_i) begin
                    state_d = (win_d >= THRESH) ? ST_DEGRADED : ST_OK;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; reset and clear both win over a beat in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            single_q      <= '0;
            multi_q       <= '0;
            win_q         <= '0;
            beat_q        <= '0;
            sat_q         <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_chunk_q <= '0;
            fault_beat_q  <= '0;
            state_q       <= ST_OK;
        end else begin
            single_q      <= single_d;
            multi_q       <= multi_d;
            win_q         <= win_d;
            beat_q        <= beat_d;
            sat_q         <= sat_d;
            fault_valid_q <= fault_valid_d;
            fault_chunk_q <= fault_chunk_d;
            fault_beat_q  <= fault_beat_d;
            state_q       <= state_d;
        end
    end

    assign single_cnt_o  = single_q;
    assign multi_cnt_o   = multi_q;
    assign win_cnt_o     = win_q;
    assign beat_cnt_o    = beat_q;
    assign sat_o         = sat_q;
    assign fault_valid_o = fault_valid_q;
    assign fault_chunk_o = fault_chunk_q;
    assign fault_beat_o  = fault_beat_q;
    assign state_o       = state_q;
    assign irq_o         = (state_q != ST_OK);

endmodule

// File: tb/tb_hci_ecc_err_monitor.sv
// Directed bench for hci_ecc_err_monitor with N_CHUNK=4, CNT_W=8, THRESHOLD=3.
module tb_hci_ecc_err_monitor;

    logic       clk = 1'b0;
    logic       rst_i, clear_i, ack_i, valid_i;
    logic [3:0] r_data_single_err_i, r_data_multi_err_i;
    logic       r_meta_single_err_i, r_meta_multi_err_i;
    logic [7:0] single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, fault_beat_o;
    logic       sat_o, fault_valid_o, irq_o;
    logic [2:0] fault_chunk_o;
    logic [1:0] state_o;

    int n_pass  = 0;
    int n_total = 0;

    hci_ecc_err_monitor #(
        .N_CHUNK  (4),
        .CNT_W    (8),
        .THRESHOLD(3)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .clear_i            (clear_i),
        .ack_i              (ack_i),
        .valid_i            (valid_i),
        .r_data_single_err_i(r_data_single_err_i),
        .r_data_multi_err_i (r_data_multi_err_i),
        .r_meta_single_err_i(r_meta_single_err_i),
        .r_meta_multi_err_i (r_meta_multi_err_i),
        .single_cnt_o       (single_cnt_o),
        .multi_cnt_o        (multi_cnt_o),
        .win_cnt_o          (win_cnt_o),
        .beat_cnt_o         (beat_cnt_o),
        .sat_o              (sat_o),
        .fault_valid_o      (fault_valid_o),
        .fault_chunk_o      (fault_chunk_o),
        .fault_beat_o       (fault_beat_o),
        .state_o            (state_o),
        .irq_o              (irq_o)
    );

    always #5 clk = ~clk;

    // Drives one cycle from a negedge; outputs are settled at the following negedge.
    task automatic step(input logic v, input logic [3:0] ds, input logic [3:0] dm,
                        input logic ms, input logic mm, input logic ack, input logic clr);
        valid_i             = v;
        r_data_single_err_i = ds;
        r_data_multi_err_i  = dm;
        r_meta_single_err_i = ms;
        r_meta_multi_err_i  = mm;
        ack_i               = ack;
        clear_i             = clr;
        @(negedge clk);
        valid_i             = 1'b0;
        r_data_single_err_i = '0;
        r_data_multi_err_i  = '0;
        r_meta_single_err_i = 1'b0;
        r_meta_multi_err_i  = 1'b0;
        ack_i               = 1'b0;
        clear_i             = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; ack_i = 1'b0; valid_i = 1'b0;
        r_data_single_err_i = '0; r_data_multi_err_i = '0;
        r_meta_single_err_i = 1'b0; r_meta_multi_err_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        n_total++;
        if ({single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, sat_o, fault_valid_o,
             fault_chunk_o, fault_beat_o, state_o} !== 46'd0)
            $display("FAIL reset_outputs: got s=%0d m=%0d w=%0d b=%0d sat=%0d fv=%0d st=%0d expected all 0",
                     single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, sat_o, fault_valid_o, state_o);
        else n_pass++;
        n_total++;
        if (irq_o !== 1'b0) $display("FAIL reset_irq: got %0d expected 0", irq_o);
        else n_pass++;
    endtask

    task automatic test_degrade_ack();
        step(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({single_cnt_o, win_cnt_o, beat_cnt_o} !== {8'd3, 8'd3, 8'd1})
            $display("FAIL deg_counts: got s=%0d w=%0d b=%0d expected s=3 w=3 b=1",
                     single_cnt_o, win_cnt_o, beat_cnt_o);
        else n_pass++;
        n_total++;
        if ({state_o, irq_o} !== {2'd1, 1'b1})
            $display("FAIL deg_state: got st=%0d irq=%0d expected st=1 irq=1", state_o, irq_o);
        else n_pass++;
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({win_cnt_o, single_cnt_o, state_o, irq_o} !== {8'd0, 8'd3, 2'd0, 1'b0})
            $display("FAIL ack_ok: got w=%0d s=%0d st=%0d irq=%0d expected w=0 s=3 st=0 irq=0",
                     win_cnt_o, single_cnt_o, state_o, irq_o);
        else n_pass++;
    endtask

    task automatic test_valid_gating();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'(i), 4'(~i), i[0], i[1], 1'b0, 1'b0);
        end
        n_total++;
        if ({single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, state_o, fault_valid_o}
            !== {8'd3, 8'd0, 8'd0, 8'd1, 2'd0, 1'b0})
            $display("FAIL gating: got s=%0d m=%0d w=%0d b=%0d st=%0d fv=%0d expected s=3 m=0 w=0 b=1 st=0 fv=0",
                     single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, state_o, fault_valid_o);
        else n_pass++;
        step(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o} !== {8'd3, 8'd1, 8'd0, 8'd2})
            $display("FAIL both_flags: got s=%0d m=%0d w=%0d b=%0d expected s=3 m=1 w=0 b=2",
                     single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o);
        else n_pass++;
        n_total++;
        if ({state_o, fault_valid_o, fault_chunk_o, fault_beat_o} !== {2'd2, 1'b1, 3'd3, 8'd1})
            $display("FAIL both_flags_fault: got st=%0d fv=%0d fc=%0d fb=%0d expected st=2 fv=1 fc=3 fb=1",
                     state_o, fault_valid_o, fault_chunk_o, fault_beat_o);
        else n_pass++;
    endtask

    task automatic test_threshold_ack_beat();
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({win_cnt_o, state_o} !== {8'd2, 2'd0})
            $display("FAIL below_thresh: got w=%0d st=%0d expected w=2 st=0", win_cnt_o, state_o);
        else n_pass++;
        step(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({win_cnt_o, state_o} !== {8'd3, 2'd1})
            $display("FAIL at_thresh: got w=%0d st=%0d expected w=3 st=1", win_cnt_o, state_o);
        else n_pass++;
        step(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({win_cnt_o, state_o} !== {8'd1, 2'd0})
            $display("FAIL ack_beat_low: got w=%0d st=%0d expected w=1 st=0", win_cnt_o, state_o);
        else n_pass++;
        step(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({win_cnt_o, state_o, single_cnt_o, beat_cnt_o} !== {8'd3, 2'd1, 8'd9, 8'd5})
            $display("FAIL ack_beat_high: got w=%0d st=%0d s=%0d b=%0d expected w=3 st=1 s=9 b=5",
                     win_cnt_o, state_o, single_cnt_o, beat_cnt_o);
        else n_pass++;
        step(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({state_o, fault_chunk_o, fault_beat_o} !== {2'd2, 3'd0, 8'd5})
            $display("FAIL ack_vs_fault: got st=%0d fc=%0d fb=%0d expected st=2 fc=0 fb=5",
                     state_o, fault_chunk_o, fault_beat_o);
        else n_pass++;
    endtask

    task automatic test_first_fault();
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({beat_cnt_o, state_o, fault_valid_o} !== {8'd5, 2'd0, 1'b0})
            $display("FAIL clean_beats: got b=%0d st=%0d fv=%0d expected b=5 st=0 fv=0",
                     beat_cnt_o, state_o, fault_valid_o);
        else n_pass++;
        step(1'b1, 4'b0000, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({fault_valid_o, fault_chunk_o, fault_beat_o, state_o, irq_o, multi_cnt_o}
            !== {1'b1, 3'd2, 8'd5, 2'd2, 1'b1, 8'd2})
            $display("FAIL first_fault: got fv=%0d fc=%0d fb=%0d st=%0d irq=%0d m=%0d expected fv=1 fc=2 fb=5 st=2 irq=1 m=2",
                     fault_valid_o, fault_chunk_o, fault_beat_o, state_o, irq_o, multi_cnt_o);
        else n_pass++;
        step(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if ({fault_chunk_o, fault_beat_o, multi_cnt_o, single_cnt_o, win_cnt_o, beat_cnt_o}
            !== {3'd2, 8'd5, 8'd3, 8'd1, 8'd1, 8'd7})
            $display("FAIL second_fault: got fc=%0d fb=%0d m=%0d s=%0d w=%0d b=%0d expected fc=2 fb=5 m=3 s=1 w=1 b=7",
                     fault_chunk_o, fault_beat_o, multi_cnt_o, single_cnt_o, win_cnt_o, beat_cnt_o);
        else n_pass++;
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({state_o, win_cnt_o} !== {2'd2, 8'd1})
            $display("FAIL fault_ack: got st=%0d w=%0d expected st=2 w=1", state_o, win_cnt_o);
        else n_pass++;
    endtask

    task automatic test_saturation_wrap();
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (51) step(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({single_cnt_o, win_cnt_o, sat_o, state_o} !== {8'd255, 8'd255, 1'b0, 2'd1})
            $display("FAIL sat_edge: got s=%0d w=%0d sat=%0d st=%0d expected s=255 w=255 sat=0 st=1",
                     single_cnt_o, win_cnt_o, sat_o, state_o);
        else n_pass++;
        step(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({single_cnt_o, win_cnt_o, sat_o} !== {8'd255, 8'd255, 1'b1})
            $display("FAIL sat_clamp: got s=%0d w=%0d sat=%0d expected s=255 w=255 sat=1",
                     single_cnt_o, win_cnt_o, sat_o);
        else n_pass++;
        repeat (12) step(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({beat_cnt_o, single_cnt_o, multi_cnt_o, sat_o} !== {8'd64, 8'd255, 8'd0, 1'b1})
            $display("FAIL sat_64: got b=%0d s=%0d m=%0d sat=%0d expected b=64 s=255 m=0 sat=1",
                     beat_cnt_o, single_cnt_o, multi_cnt_o, sat_o);
        else n_pass++;
        repeat (191) step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (beat_cnt_o !== 8'd255)
            $display("FAIL beat_max: got %0d expected 255", beat_cnt_o);
        else n_pass++;
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({beat_cnt_o, sat_o} !== {8'd0, 1'b1})
            $display("FAIL beat_wrap: got b=%0d sat=%0d expected b=0 sat=1", beat_cnt_o, sat_o);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        step(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if ({single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, sat_o, fault_valid_o,
             fault_chunk_o, fault_beat_o, state_o, irq_o} !== 47'd0)
            $display("FAIL clear_beat: got s=%0d m=%0d w=%0d b=%0d sat=%0d fv=%0d st=%0d irq=%0d expected all 0",
                     single_cnt_o, multi_cnt_o, win_cnt_o, beat_cnt_o, sat_o, fault_valid_o, state_o, irq_o);
        else n_pass++;
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({beat_cnt_o, multi_cnt_o, state_o} !== {8'd0, 8'd0, 2'd0})
            $display("FAIL clear_hold: got b=%0d m=%0d st=%0d expected b=0 m=0 st=0",
                     beat_cnt_o, multi_cnt_o, state_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_degrade_ack();
        test_valid_gating();
        test_threshold_ack_beat();
        test_first_fault();
        test_saturation_wrap();
        test_clear_priority();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
